// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Two-entry pipeline register with a skid buffer. in_ready and out_valid are
//   decoded from the state register only. There is no combinational path from
//   out_ready to in_ready. A stalled downstream therefore costs one extra
//   entry of storage and no timing path.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   flush      synchronous discard of held entries (stall_cnt untouched)
//   cnt_clr    synchronous clear of stall_cnt (wins over increment)
//   in_valid   / in_ready  / in_ctrl  / in_data   upstream handshake + entry
//   out_valid  / out_ready / out_ctrl / out_data  downstream handshake + entry
//   occupancy  held entries: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | nothing held; main/skid don't care
// S_ONE   | main holds the oldest entry; skid unused
// S_FULL  | main holds the oldest entry, skid the next one; in_ready = 0

module pipe_stage_skid #(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 24,
  parameter int CNT_W         = 16,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // Flush beats any same-cycle transfer; the incoming entry is dropped.
      state     <= S_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_valid) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_valid) begin
            if (out_ready) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else begin
              // Downstream stalled: park the new entry behind main.
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
              state     <= S_FULL;
            end
          end else if (out_ready) begin
            state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign in_ready  = (state == S_EMPTY) || (state == S_ONE);
  assign out_valid = (state == S_ONE) || (state == S_FULL);
  assign occupancy = state;

  // main can still hold a stale entry after draining to S_EMPTY, so mask it.
  generate
    if (ZERO_ON_EMPTY) begin : g_zero_empty
      assign out_ctrl = out_valid ? main_ctrl : '0;
      assign out_data = out_valid ? main_data : '0;
    end else begin : g_raw
      assign out_ctrl = main_ctrl;
      assign out_data = main_data;
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
Parameters:
REQ-001 DATA_W, 32, payload width; covers ALU results, store data and write-register fields.
REQ-002 CTRL_W, 24, width of the control-signal bundle carried alongside the payload.
REQ-003 CNT_W, 16, width of the stall counter.
REQ-004 ZERO_ON_EMPTY, 1, when 1 the out_ctrl and out_data outputs are forced to 0 whenever out_valid=0.

Ports:
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  synchronous discard of all held entries.
REQ-008 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-009 in_valid  in  1  upstream presents an entry.
REQ-010 in_ready  out  1  stage can accept an entry this cycle.
REQ-011 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-012 in_data  in  DATA_W  upstream payload.
REQ-013 out_valid  out  1  stage presents an entry downstream.
REQ-014 out_ready  in  1  downstream accepts the presented entry.
REQ-015 out_ctrl  out  CTRL_W  held control bundle.
REQ-016 out_data  out  DATA_W  held payload.
REQ-017 occupancy  out  2  number of held entries (0, 1 or 2).
REQ-018 stall_cnt  out  CNT_W  saturating count of downstream-stall cycles.

Function
REQ-019 Storage SHALL consist of one main register and one skid register, each holding {ctrl,data}.
REQ-020 The FSM SHALL have three states: EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-021 Input transfer SHALL occur when in_valid&in_ready; output transfer SHALL occur when out_valid&out_ready.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from out_ready.
REQ-023 out_valid SHALL be 1 in ONE and FULL; out_ctrl and out_data SHALL always come from the main register.
REQ-024 EMPTY: in_valid -> main<=input, go to ONE; otherwise stay in EMPTY.
REQ-025 ONE: in_valid&out_ready -> main<=input, stay in ONE; in_valid&!out_ready -> skid<=input, go to FULL; !in_valid&out_ready -> go to EMPTY; otherwise hold.
REQ-026 FULL: out_ready -> main<=skid, go to ONE; otherwise hold both registers.
REQ-027 Latency SHALL be 1 cycle from input transfer to out_valid when the stage is empty.
REQ-028 Entries SHALL leave in arrival order; no entry is dropped or duplicated except by flush or clr.
REQ-029 Throughput SHALL be one entry per cycle while out_ready=1.
REQ-030 flush=1 SHALL force the next state to EMPTY and zero both registers, overriding any same-cycle input or output transfer (the input entry is discarded).
REQ-031 While out_valid=0 and ZERO_ON_EMPTY=1, out_ctrl and out_data SHALL be 0.
REQ-032 stall_cnt SHALL increment by 1 each cycle that out_valid&!out_ready and SHALL saturate at 2^CNT_W-1.
REQ-033 cnt_clr SHALL zero stall_cnt on the next edge, taking priority over an increment; flush SHALL NOT affect stall_cnt.
REQ-034 occupancy SHALL equal the encoded state: EMPTY=0, ONE=1, FULL=2.

Reset
REQ-035 clr=1 SHALL immediately, independent of clk, force: state EMPTY, both registers 0, out_valid 0, in_ready 1, occupancy 0, stall_cnt 0.
REQ-036 clr SHALL dominate flush, cnt_clr and all transfers; asserting clr mid-operation SHALL discard held entries.
REQ-037 On the first edge after clr falls, the stage SHALL accept input normally.

Verification
REQ-038 Streaming: out_ready=1, in_valid=1, in_data=1,2,3 on consecutive cycles -> out_data=1,2,3 one cycle later, occupancy stays 1, stall_cnt=0.
REQ-039 Skid: in_data=0xA then 0xB, out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA; raise out_ready -> out_data 0xA then 0xB, then out_valid=0.
REQ-040 Flush collision: FULL state plus in_valid=1 and flush=1 in the same cycle -> next cycle occupancy 0, out_valid 0, out_data 0, and the input entry never appears.
REQ-041 Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr=1 -> 0.
REQ-042 Async reset: assert clr between clock edges while in FULL -> outputs reach reset values before the next edge; deassert clr, then in_data=0x5 -> out_data=0x5 after 1 cycle.
REQ-043 Back-pressure randomised: random in_valid and out_ready over 10,000 cycles -> output sequence equals the input sequence exactly, and in_ready=0 only in FULL.
